exhaustive_tt_checker: RTL and testbench

//  Sequential self-checking stimulus engine for combinational DUTs: drives all 2^N_IN input

---
 rtl/exhaustive_tt_checker_pkg.sv | 20 ++
 rtl/exhaustive_tt_checker_if.sv | 29 ++
 rtl/tt_dwell_timer.sv | 41 ++++
 rtl/exhaustive_tt_checker.sv | 141 ++++++++++++++
 tb/tb_exhaustive_tt_checker.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/exhaustive_tt_checker_pkg.sv
// Shared definitions for the exhaustive truth-table checker: FSM state encodings
// and the width helper for the dwell counter.
`default_nettype none

package exhaustive_tt_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } tt_state_e;

    // A counter that must hold values 0..n-1 needs at least one bit even when n==1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exhaustive_tt_checker_if.sv
// Control, status and DUT-facing signals of the exhaustive truth-table checker.
`default_nettype none

interface exhaustive_tt_checker_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic [2**N_IN-1:0]   expected_tt;
    logic [N_IN-1:0]      dut_in;
    logic                 dut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail_vec;
    logic                 first_fail_vld;

    modport master (
        output start, expected_tt, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_vld
    );

    modport slave (
        input  start, expected_tt, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_vld
    );
endinterface

`default_nettype wire

// File: rtl/tt_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled and ticks on the last count.
`default_nettype none

module tt_dwell_timer
    import exhaustive_tt_checker_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      tick
);
    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exhaustive_tt_checker.sv
// Exhaustive truth-table checker: sweeps all 2^N_IN vectors, compares the DUT response
// against expected_tt. Optional STOP_ON_FAIL_EN ends the sweep at the first mismatch.
`default_nettype none

module exhaustive_tt_checker
    import exhaustive_tt_checker_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int DWELL = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    exhaustive_tt_checker_if.slave  bus
);
    localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_MAX = {1'b1, {N_IN{1'b0}}};

    tt_state_e         state_q, state_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;
    logic              first_fail_vld_q, first_fail_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              tmr_clr;
    logic              tmr_en;
    logic              tick;
    logic              mismatch;
    logic              end_sweep;
    logic [N_IN:0]     err_next;

    tt_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .tick (tick)
    );

    always_comb begin
        state_d          = state_q;
        dut_in_d         = dut_in_q;
        err_count_d      = err_count_q;
        first_fail_vec_d = first_fail_vec_q;
        first_fail_vld_d = first_fail_vld_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        tmr_clr          = 1'b0;
        tmr_en           = 1'b0;
        mismatch         = 1'b0;
        end_sweep        = 1'b0;
        err_next         = err_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d          = ST_APPLY;
                    dut_in_d         = '0;
                    err_count_d      = '0;
                    first_fail_vld_d = 1'b0;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    tmr_clr          = 1'b1;
                end
            end
            ST_APPLY: begin
                tmr_en = 1'b1;
                if (tick) begin
                    mismatch = (bus.dut_out != bus.expected_tt[dut_in_q]);
                    if (mismatch) begin
                        err_next = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + 1'b1;
                        if (!first_fail_vld_q) begin
                            first_fail_vec_d = dut_in_q;
                            first_fail_vld_d = 1'b1;
                        end
                    end
                    err_count_d = err_next;
`ifdef STOP_ON_FAIL_EN
                    end_sweep = mismatch || (dut_in_q == VEC_MAX);
`else
                    end_sweep = (dut_in_q == VEC_MAX);
`endif
                    // The last vector (or a stop) holds dut_in so the result refers to it.
                    if (end_sweep) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_next == '0);
                    end else begin
                        dut_in_d = dut_in_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            dut_in_q         <= '0;
            err_count_q      <= '0;
            first_fail_vec_q <= '0;
            first_fail_vld_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            dut_in_q         <= dut_in_d;
            err_count_q      <= err_count_d;
            first_fail_vec_q <= first_fail_vec_d;
            first_fail_vld_q <= first_fail_vld_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign bus.dut_in         = dut_in_q;
    assign bus.err_count      = err_count_q;
    assign bus.first_fail_vec = first_fail_vec_q;
    assign bus.first_fail_vld = first_fail_vld_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_exhaustive_tt_checker.sv
// Bench for exhaustive_tt_checker: table of sweeps on a 4-input/DWELL=2 instance plus
// hand sequences for reset, start-while-busy, restart and a 3-input/DWELL=1 instance.
`default_nettype none

module tb_exhaustive_tt_checker;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   mode_a;

    exhaustive_tt_checker_if #(.N_IN(4)) bus_a ();
    exhaustive_tt_checker_if #(.N_IN(3)) bus_b ();

    exhaustive_tt_checker #(.N_IN(4), .DWELL(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    exhaustive_tt_checker #(.N_IN(3), .DWELL(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: xor, 1: xor inverted at vector 5, 2: stuck-at-0, 3: xnor (every vector wrong)
    function automatic logic model_a(input int mode, input logic [3:0] v);
        case (mode)
            0:       return ^v;
            1:       return (^v) ^ (v == 4'd5);
            2:       return 1'b0;
            3:       return ~(^v);
            default: return ^v;
        endcase
    endfunction

    assign bus_a.dut_out = model_a(mode_a, bus_a.dut_in);
    assign bus_b.dut_out = (bus_b.dut_in[0] & bus_b.dut_in[1]) |
                           (bus_b.dut_in[1] & bus_b.dut_in[2]) |
                           (bus_b.dut_in[0] & bus_b.dut_in[2]);

    typedef struct {
        int          mode;
        logic [15:0] tt;
        int          exp_busy;
        int          exp_err;
        int          exp_ffv;
        int          exp_vld;
        int          exp_pass;
        int          exp_last;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Pulse start on instance A and count the cycles busy stays high.
    task automatic sweep_a(output int cycles);
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        cycles = 0;
        while (bus_a.busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 200) check("sweep_a_timeout", cycles, -1);
    endtask

    initial begin
        int cyc;
        n_cmp  = 0;
        n_fail = 0;
        mode_a = 0;
        bus_a.start       = 1'b0;
        bus_a.expected_tt = 16'h6996;
        bus_b.start       = 1'b0;
        bus_b.expected_tt = 8'hE8;

        // mode, tt, busy, err, ffv, vld, pass, last dut_in
`ifdef STOP_ON_FAIL_EN
        tbl[0] = '{0, 16'h6996, 32, 0,  0, 0, 1, 15};
        tbl[1] = '{1, 16'h6996, 12, 1,  5, 1, 0,  5};
        tbl[2] = '{2, 16'h6996,  4, 1,  1, 1, 0,  1};
        tbl[3] = '{3, 16'h6996,  2, 1,  0, 1, 0,  0};
        tbl[4] = '{2, 16'h0000, 32, 0,  0, 0, 1, 15};
`else
        tbl[0] = '{0, 16'h6996, 32, 0,  0, 0, 1, 15};
        tbl[1] = '{1, 16'h6996, 32, 1,  5, 1, 0, 15};
        tbl[2] = '{2, 16'h6996, 32, 8,  1, 1, 0, 15};
        tbl[3] = '{3, 16'h6996, 32, 16, 0, 1, 0, 15};
        tbl[4] = '{2, 16'h0000, 32, 0,  0, 0, 1, 15};
`endif

        rst = 1'b1;
        #12;
        check("rst_busy",   int'(bus_a.busy), 0);
        check("rst_done",   int'(bus_a.done), 0);
        check("rst_pass",   int'(bus_a.pass), 0);
        check("rst_err",    int'(bus_a.err_count), 0);
        check("rst_dut_in", int'(bus_a.dut_in), 0);
        check("rst_vld",    int'(bus_a.first_fail_vld), 0);
        check("rst_b_busy", int'(bus_b.busy), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mode_a = tbl[i].mode;
            bus_a.expected_tt = tbl[i].tt;
            sweep_a(cyc);
            check($sformatf("row%0d_busy_cycles", i), cyc, tbl[i].exp_busy);
            check($sformatf("row%0d_done", i), int'(bus_a.done), 1);
            check($sformatf("row%0d_err", i), int'(bus_a.err_count), tbl[i].exp_err);
            check($sformatf("row%0d_vld", i), int'(bus_a.first_fail_vld), tbl[i].exp_vld);
            if (tbl[i].exp_vld != 0)
                check($sformatf("row%0d_ffv", i), int'(bus_a.first_fail_vec), tbl[i].exp_ffv);
            check($sformatf("row%0d_pass", i), int'(bus_a.pass), tbl[i].exp_pass);
            check($sformatf("row%0d_last_vec", i), int'(bus_a.dut_in), tbl[i].exp_last);
            repeat (3) @(negedge clk);
            check($sformatf("row%0d_done_held", i), int'(bus_a.done), 1);
        end

        // Async reset mid-sweep: outputs clear without waiting for a clock edge.
        mode_a = 2;
        bus_a.expected_tt = 16'h6996;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", int'(bus_a.busy), 0);
        check("async_rst_done", int'(bus_a.done), 0);
        check("async_rst_err",  int'(bus_a.err_count), 0);
        check("async_rst_vec",  int'(bus_a.dut_in), 0);
        check("async_rst_vld",  int'(bus_a.first_fail_vld), 0);
        @(negedge clk);
        rst = 1'b0;
        mode_a = 0;
        sweep_a(cyc);
        check("post_rst_busy_cycles", cyc, 32);
        check("post_rst_pass", int'(bus_a.pass), 1);

        // start pulsed while busy must not restart or stretch the sweep.
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc = 0;
        while (bus_a.busy && cyc < 200) begin
            cyc++;
            bus_a.start = (cyc == 5);
            @(negedge clk);
        end
        bus_a.start = 1'b0;
        check("start_in_busy_cycles", cyc, 32);
        check("start_in_busy_pass", int'(bus_a.pass), 1);

        // Restart from DONE clears the scoreboard on the entry edge.
        mode_a = 2;
        sweep_a(cyc);
        check("pre_restart_err", int'(bus_a.err_count) > 0 ? 1 : 0, 1);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        check("restart_err",    int'(bus_a.err_count), 0);
        check("restart_busy",   int'(bus_a.busy), 1);
        check("restart_done",   int'(bus_a.done), 0);
        check("restart_vld",    int'(bus_a.first_fail_vld), 0);
        check("restart_dut_in", int'(bus_a.dut_in), 0);
        cyc = 0;
        while (bus_a.busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end

        // 3-input majority, one cycle per vector.
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        cyc = 0;
        while (bus_b.busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("maj_busy_cycles", cyc, 8);
        check("maj_done", int'(bus_b.done), 1);
        check("maj_pass", int'(bus_b.pass), 1);
        check("maj_err",  int'(bus_b.err_count), 0);
        check("maj_last", int'(bus_b.dut_in), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
